// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first. Byte stream in via valid/ready; CS stays low
// across bytes until a byte flagged last completes, then hold and gap phases.
module spi_master #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] spi_sclk_div_i,
  input  logic [7:0]      spi_tx_data_i,
  input  logic            spi_tx_last_i,
  input  logic            spi_tx_data_vld_i,
  output logic            spi_tx_data_rdy_o,
  input  logic            spi_miso_i,
  output logic            spi_sclk_o,
  output logic            spi_mosi_o,
  output logic            spi_cs_n_o,
  output logic [7:0]      spi_rx_data_o,
  output logic            spi_rx_data_vld_o,
  output logic            spi_busy_o
);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, HOLD, GAP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] div, div_nxt;
  logic [XLEN-1:0] cnt, cnt_nxt;
  logic [3:0]      edges, edges_nxt;
  logic [7:0]      tx, tx_nxt;
  logic [7:0]      rx_sh, rx_sh_nxt;
  logic [7:0]      rx_data, rx_data_nxt;
  logic            last, last_nxt;
  logic            sclk, sclk_nxt;
  logic            mosi, mosi_nxt;
  logic            rx_vld, rx_vld_nxt;
  logic            half_done;

  // Half-period boundary: counter runs 0..div of the divider latched at accept.
  assign half_done = (cnt == div);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      div     <= '0;
      cnt     <= '0;
      edges   <= '0;
      tx      <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      last    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_vld  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      cnt     <= cnt_nxt;
      edges   <= edges_nxt;
      tx      <= tx_nxt;
      rx_sh   <= rx_sh_nxt;
      rx_data <= rx_data_nxt;
      last    <= last_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      rx_vld  <= rx_vld_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_nxt     = div;
    cnt_nxt     = cnt;
    edges_nxt   = edges;
    tx_nxt      = tx;
    rx_sh_nxt   = rx_sh;
    rx_data_nxt = rx_data;
    last_nxt    = last;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    rx_vld_nxt  = 1'b0;
    unique case (state)
      IDLE, WAIT: begin
        if (spi_tx_data_vld_i) begin
          tx_nxt    = spi_tx_data_i;
          last_nxt  = spi_tx_last_i;
          div_nxt   = spi_sclk_div_i;
          cnt_nxt   = '0;
          edges_nxt = '0;
          sclk_nxt  = 1'b0;
          mosi_nxt  = spi_tx_data_i[7];
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (half_done) begin
          cnt_nxt   = '0;
          edges_nxt = edges + 4'd1;
          sclk_nxt  = ~sclk;
          if (!sclk) begin
            rx_sh_nxt = {rx_sh[6:0], spi_miso_i};
          end else if (edges == 4'd15) begin
            // Final falling edge: byte complete, mosi left on bit 0.
            rx_data_nxt = rx_sh;
            rx_vld_nxt  = 1'b1;
            state_nxt   = last ? HOLD : WAIT;
          end else begin
            tx_nxt   = {tx[6:0], 1'b0};
            mosi_nxt = tx[6];
          end
        end else begin
          cnt_nxt = cnt + XLEN'(1);
        end
      end
      HOLD: begin
        if (half_done) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + XLEN'(1);
        end
      end
      GAP: begin
        if (half_done) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + XLEN'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign spi_tx_data_rdy_o = (state == IDLE) || (state == WAIT);
  assign spi_cs_n_o        = (state == IDLE) || (state == GAP);
  assign spi_busy_o        = (state != IDLE);
  assign spi_sclk_o        = sclk;
  assign spi_mosi_o        = mosi;
  assign spi_rx_data_o     = rx_data;
  assign spi_rx_data_vld_o = rx_vld;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a slave model drives MISO, a scoreboard holds
// the expected MOSI/MISO byte pair of every accepted byte.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] div;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_vld;
  logic        rdy;
  logic        miso;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        busy;

  spi_master #(.XLEN(32)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .spi_sclk_div_i    (div),
    .spi_tx_data_i     (tx_data),
    .spi_tx_last_i     (tx_last),
    .spi_tx_data_vld_i (tx_vld),
    .spi_tx_data_rdy_o (rdy),
    .spi_miso_i        (miso),
    .spi_sclk_o        (sclk),
    .spi_mosi_o        (mosi),
    .spi_cs_n_o        (cs_n),
    .spi_rx_data_o     (rx_data),
    .spi_rx_data_vld_o (rx_vld),
    .spi_busy_o        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         rises = 0;
  int         vld_seen = 0;
  int         cs_high = 0;
  int         mosi_bad = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;
  logic [7:0] mosi_acc = '0;
  logic [7:0] slave_sh = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step; observes the bus at the falling clk edge and plays the slave.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (cs_n) cs_high++;
    if (sclk && prev_sclk && (mosi !== prev_mosi)) mosi_bad++;
    if (sclk && !prev_sclk) begin
      rises++;
      mosi_acc = {mosi_acc[6:0], mosi};
      if (cs_n) mosi_bad++;
    end
    if (!sclk && prev_sclk) begin
      miso     = slave_sh[7];
      slave_sh = {slave_sh[6:0], 1'b0};
    end
    if (rx_vld) begin
      vld_seen++;
      check("vld_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.rx));
        check("mosi_byte", 32'(mosi_acc), 32'(e.tx));
      end
    end
    prev_sclk = sclk;
    prev_mosi = mosi;
  endtask

  task automatic send(input logic [7:0] data, input logic last, input logic [7:0] slave,
                      input logic keep);
    tx_data = data;
    tx_last = last;
    tx_vld  = 1'b1;
    for (int n = 0; n < 400 && !rdy; n++) tick();
    check("accept_rdy", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) tx_vld = 1'b0;
    miso     = slave[7];
    slave_sh = {slave[6:0], 1'b0};
    sb.push_back('{tx: data, rx: slave});
    t0 = cyc + 1;
  endtask

  // sel: 0 = rx_vld pulse, 1 = cs_n high, 2 = ready (idle)
  task automatic wait_for(input int sel, input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (sel == 0 && rx_vld) return;
      if (sel == 1 && cs_n) return;
      if (sel == 2 && rdy && !busy) return;
    end
  endtask

  initial begin
    int t0a;
    int bad;
    int r0;
    rst_n   = 1'b0;
    div     = 32'd1;
    tx_data = '0;
    tx_last = 1'b0;
    tx_vld  = 1'b0;
    miso    = 1'b0;
    repeat (2) tick();
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_vld", 32'(rx_vld), 32'd0);
    rst_n = 1'b1;
    tick();

    // div=1: single A5 frame, slave returns 3C
    send(8'hA5, 1'b1, 8'h3C, 1'b0);
    tick();
    check("shift_busy", 32'(busy), 32'd1);
    check("shift_cs_n", 32'(cs_n), 32'd0);
    check("shift_rdy", 32'(rdy), 32'd0);
    wait_for(0, 200);
    check("a5_vld_time", 32'(cyc - t0), 32'd32);
    tick();
    check("a5_vld_pulse", 32'(rx_vld), 32'd0);
    check("a5_rx_hold", 32'(rx_data), 32'h3C);
    wait_for(1, 50);
    check("a5_cs_time", 32'(cyc - t0), 32'd34);
    wait_for(2, 50);
    check("a5_rdy_time", 32'(cyc - t0), 32'd36);

    // div=0: back-to-back 01 then FF in one CS frame
    div   = 32'd0;
    rises = 0;
    vld_seen = 0;
    send(8'h01, 1'b0, 8'hC6, 1'b1);
    t0a = t0;
    cs_high = 0;
    send(8'hFF, 1'b1, 8'h7E, 1'b0);
    wait_for(0, 200);
    check("b2b_vld_time", 32'(cyc - t0a), 32'd33);
    check("b2b_rises", 32'(rises), 32'd16);
    check("b2b_vld_count", 32'(vld_seen), 32'd2);
    check("b2b_cs_low", 32'(cs_high), 32'd0);
    wait_for(2, 50);
    check("b2b_rdy_time", 32'(cyc - t0), 32'd18);

    // WAIT: next byte withheld for 50 cycles
    div = 32'd1;
    send(8'h6E, 1'b0, 8'h81, 1'b0);
    wait_for(0, 200);
    r0  = rises;
    bad = 0;
    repeat (50) begin
      tick();
      if (cs_n !== 1'b0 || sclk !== 1'b0 || rdy !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("wait_bad_cycles", 32'(bad), 32'd0);
    check("wait_no_sclk", 32'(rises), 32'(r0));
    send(8'h92, 1'b1, 8'h5B, 1'b0);
    wait_for(0, 200);
    check("wait_next_vld_time", 32'(cyc - t0), 32'd32);
    wait_for(2, 50);

    // reset after the third rising SCLK edge
    send(8'hC3, 1'b1, 8'hAA, 1'b0);
    rises = 0;
    for (int n = 0; n < 100 && rises < 3; n++) tick();
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_rdy", 32'(rdy), 32'd1);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sb.delete();
    vld_seen = 0;
    repeat (3) tick();
    check("abort_no_vld", 32'(vld_seen), 32'd0);
    rst_n = 1'b1;
    tick();
    send(8'h5A, 1'b1, 8'h96, 1'b0);
    wait_for(0, 200);
    check("post_rst_vld_time", 32'(cyc - t0), 32'd32);
    wait_for(2, 50);

    // divider change and stray valid while busy
    div = 32'd1;
    send(8'hB7, 1'b0, 8'h11, 1'b0);
    t0a = t0;
    repeat (4) tick();
    div     = 32'd3;
    tx_data = 8'hEE;
    tx_last = 1'b1;
    tx_vld  = 1'b1;
    repeat (2) tick();
    tx_vld = 1'b0;
    wait_for(0, 200);
    check("div_keep_vld_time", 32'(cyc - t0a), 32'd32);
    send(8'h4D, 1'b1, 8'hE2, 1'b0);
    wait_for(0, 300);
    check("div_new_vld_time", 32'(cyc - t0), 32'd64);
    wait_for(1, 50);
    check("div_new_cs_time", 32'(cyc - t0), 32'd68);
    wait_for(2, 50);
    check("div_new_rdy_time", 32'(cyc - t0), 32'd72);

    repeat (5) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("mosi_stable", 32'(mosi_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have one parameter: none besides XLEN; XLEN, default 32, width of spi_sclk_div_i.
REQ-002 clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 spi_sclk_div_i  input  XLEN  SCLK half-period minus one, in clk_i cycles; half-period H = div+1.
REQ-005 spi_tx_data_i  input  8  byte to transmit.
REQ-006 spi_tx_last_i  input  1  byte is last of frame; CS deasserts after it.
REQ-007 spi_tx_data_vld_i  input  1  byte offered.
REQ-008 spi_tx_data_rdy_o  output  1  byte accepted when vld & rdy at a rising edge.
REQ-009 spi_miso_i  input  1  serial data from slave.
REQ-010 spi_sclk_o, spi_mosi_o, spi_cs_n_o  output  1 each  SPI bus, mode 0, MSB first.
REQ-011 spi_rx_data_o  output  8  byte received during last transfer.
REQ-012 spi_rx_data_vld_o  output  1  one-cycle pulse, spi_rx_data_o valid.
REQ-013 spi_busy_o  output  1  high in any state except IDLE.

Function
REQ-014 States SHALL be IDLE, SHIFT, WAIT, HOLD, GAP.
REQ-015 IDLE: cs_n=1, sclk=0, rdy=1; on accept, latch data, last flag, div; cs_n=0, mosi=bit7 from next cycle (T0); go SHIFT.
REQ-016 SHIFT: rdy=0; sclk rises at T0+(2k+1)H, falls at T0+(2k+2)H, k=0..7.
REQ-017 MISO SHALL be sampled on the clk_i edge where sclk is driven high, shifted in LSB side.
REQ-018 mosi SHALL change only on the cycle sclk is driven low (bits 6..0 in order); stable while sclk high.
REQ-019 At T0+16H: spi_rx_data_o updated, spi_rx_data_vld_o pulses one cycle; sclk=0.
REQ-020 At T0+16H, last=1 -> HOLD; last=0 -> WAIT.
REQ-021 WAIT: cs_n=0, sclk=0, rdy=1; on accept, latch byte/last/div, load mosi; next cycle becomes new T0, go SHIFT; no timeout.
REQ-022 HOLD: cs_n=0 for H cycles, then cs_n=1, go GAP.
REQ-023 GAP: cs_n=1, rdy=0 for H cycles, then IDLE (rdy=1 at T0+18H).
REQ-024 Half-period counter SHALL count 0..latched div then wrap; div=0 gives sclk = clk_i/2.
REQ-025 Changes on spi_sclk_div_i SHALL take effect only at next accept.
REQ-026 vld while rdy=0 SHALL be ignored and not consumed; data/last sampled only at accept.
REQ-027 spi_busy_o SHALL be 0 only in IDLE.

Reset
REQ-028 While rst_n_i=0, regardless of clock: state=IDLE, cs_n=1, sclk=0, mosi=0, rdy=1, busy=0, rx_data=8'h00, rx_vld=0.
REQ-029 Reset mid-frame SHALL abort immediately with no rx_vld pulse; first accept after release starts a fresh frame.

Verification
REQ-030 div=1, send 8'hA5 last=1, slave returns 8'h3C -> mosi 1,0,1,0,0,1,0,1 on rising edges; rx_data=8'h3C, vld pulse at T0+32; cs_n high at T0+34; rdy at T0+36.
REQ-031 div=0, two bytes 8'h01 (last=0), 8'hFF (last=1), second offered immediately -> cs_n low throughout both bytes, 16 sclk pulses, two rx_vld pulses, sclk=clk/2.
REQ-032 Hold vld with last=0 byte, then withhold next byte 50 cycles -> WAIT: cs_n stays 0, sclk 0, rdy 1, no extra sclk edges.
REQ-033 Assert rst_n_i=0 after 3rd rising sclk edge -> cs_n=1, sclk=0, rdy=1 same cycle; no rx_vld; next 8'h5A frame completes correctly.
REQ-034 Change div 1->3 mid-byte, pulse vld while busy -> current byte keeps H=2, extra vld not consumed; next accepted byte uses H=4.
